ll_to_fifo36_packer: RTL
========================

// Module: ll_to_fifo36_packer
// PURPOSE
//  Parametrised successor to the ll8_to_fifo36 packer: packs an active-high LocalLink stream of
//  LLW-bit beats (8 or 16) into 36-bit FIFO words for the MAC-side 2-clock FIFO chain.
//  Adds frame byte-length reporting, error tagging, protocol-error detection and orphan-beat dropping.
//  Single clock domain; sits between the rx short FIFO and the rx 2-clock FIFO.
// PARAMETERS
//  LLW      8  LL beat width in bits. Only 8 and 16 are legal; any other value is an elaboration error.
//  LENW    16  width of frame_len; the count saturates at all-ones.
// PORTS
//  clk            in   1      clock
//  reset          in   1      synchronous, active-high
//  clear          in   1      synchronous flush; same effect as reset, except that err_cnt is kept
//  ll_data        in   LLW    beat data; for LLW=16, [15:8] is the earlier byte
//  ll_sof         in   1      first beat of frame
//  ll_eof         in   1      last beat of frame
//  ll_half        in   1      LLW=16 only: eof beat carries only [15:8]; ignored when LLW=8
//  ll_error       in   1      beat belongs to a bad frame; sticky for the rest of the frame
//  ll_src_rdy     in   1      beat valid
//  ll_dst_rdy     out  1      beat accepted when ll_src_rdy & ll_dst_rdy
//  f36_data       out  36     [31:0] data, first byte in [31:24]; [32] sof; [33] eof; [35:34] occ
//  f36_src_rdy_o  out  1      output word valid
//  f36_dst_rdy_i  in   1      downstream accepts the word
//  frame_done     out  1      one-cycle pulse when an eof beat is accepted
//  frame_len      out  LENW   byte count of the completed frame; held until the next frame_done
//  frame_err      out  1      valid with frame_done: ll_error or a protocol error occurred in the frame
//  err_cnt        out  16     count of frames with frame_err; wraps at 16 bits
// BEHAVIOUR
//  Reset: all outputs are 0, including ll_dst_rdy and err_cnt. FSM goes to IDLE; accumulator and output register are empty.
//  Beat-to-word mapping
//   - LANES = 32/LLW.
//   - The accumulator fills from the MSB lane downward; lane index wraps 0..LANES-1.
//   - A word closes when its last lane fills, or on an eof beat.
//  occ encoding: 0 = all 4 bytes valid; 1, 2, 3 = that many valid bytes. Invalid bytes read as 0.
//  Output register: a single skid register.
//   - A closed word loads into it in the cycle after the closing beat is accepted.
//   - f36_src_rdy_o stays high until f36_dst_rdy_i.
//  ll_dst_rdy = ~closing_beat_pending | ~out_valid | f36_dst_rdy_i.
//   - Full throughput: one beat per clk with no bubbles while downstream is ready.
//  sof bit is set on the first word of a frame; eof bit on the last word. Both are set for a frame of 4 bytes or fewer.
//  FSM
//   - IDLE: beat with sof -> PACK (a beat with sof & eof completes a 1-beat frame and stays in IDLE).
//     Beat without sof -> DROP, with protocol error.
//   - PACK: accept beats. An eof beat -> IDLE. A sof beat mid-frame is packed as data,
//     flags a protocol error and is not treated as a restart.
//   - DROP: ll_dst_rdy = 1; beats are discarded and not counted.
//     eof beat -> IDLE and pulses frame_done with frame_err=1, frame_len=0.
//  Length counting
//   - Adds 1 byte per beat for LLW=8.
//   - Adds 2 bytes per beat for LLW=16, or 1 on an eof beat with ll_half.
//   - Saturates at {LENW{1}}.
//  err_cnt increments on each frame_done with frame_err=1.
//  Simultaneous events
//   - Output handshake and a new word close in the same cycle: the register reloads with no bubble.
//   - A frame may start in the same cycle that the previous eof word is still held in the output register.
//  clear / reset mid-frame: the partial word and the pending output word are discarded; no eof is emitted.
//   Downstream recovers on the next sof.
// STRUCTURE
//  Shared package ll_fifo_pkg holds:
//   - f36 field constants: F36_SOF=32, F36_EOF=33, F36_OCC_HI=35, F36_OCC_LO=34;
//   - occ encoding localparams;
//   - FSM state encoding {IDLE, PACK, DROP}.
//  One sub-module, f36_out_reg: the skid/output register with its src/dst handshake, reusable for fifo36_to_ll.
//  Lane packing, the FSM and the counters stay in this module.
// TESTING
//  1. LLW=8, 6-byte frame 01..06, dst always ready:
//     -> words 0x1_01020304 (sof), then 0xA_05060000 (eof, occ=2);
//     frame_len=6, frame_err=0.
//  2. LLW=16, beats 0xAABB,0xCCDD,0xEE00 with ll_half on the eof beat
//     -> words {sof, AABBCCDD}, {eof, occ=1, EE000000}; frame_len=5.
//  3. LLW=8, 1-byte frame 0x5A with sof&eof -> word 0x7_5A000000, frame_len=1.
//  4. Backpressure: f36_dst_rdy_i toggles 1/0 every cycle over a 64-byte frame
//     -> no data loss or duplication; ll_dst_rdy low only while a closing beat waits.
//  5. Orphan beats (no sof) 3 bytes then eof -> no f36 output; frame_done with frame_err=1, frame_len=0; err_cnt=1.
//  6. ll_error on beat 3 of 8, then clear asserted mid-next-frame
//     -> frame_err=1 on the first frame; the second frame produces no eof word; err_cnt is kept.

Source files
------------

// File: rtl/ll_fifo_pkg.sv
// ll_fifo_pkg
//   Shared definitions for the LocalLink <-> FIFO36 adapters:
//   - bit positions of the sideband fields inside a 36-bit FIFO word
//   - occupancy (occ) encoding of the last word of a frame
//   - packer FSM state encoding
//   - occ_from_bytes(): maps a valid-byte count (1..4) to the occ field
package ll_fifo_pkg;

    // f36 word layout: [31:0] data (first byte in [31:24]), [32] sof, [33] eof, [35:34] occ
    localparam int F36_SOF    = 32;
    localparam int F36_EOF    = 33;
    localparam int F36_OCC_HI = 35;
    localparam int F36_OCC_LO = 34;

    // occ encoding: 0 means the whole word is valid, otherwise the count of valid bytes
    localparam logic [1:0] OCC_FULL  = 2'd0;
    localparam logic [1:0] OCC_BYTE1 = 2'd1;
    localparam logic [1:0] OCC_BYTE2 = 2'd2;
    localparam logic [1:0] OCC_BYTE3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DROP = 2'd2
    } ll_state_e;

    function automatic logic [1:0] occ_from_bytes(input logic [2:0] n_bytes);
        logic [1:0] occ;
        case (n_bytes)
            3'd1:    occ = OCC_BYTE1;
            3'd2:    occ = OCC_BYTE2;
            3'd3:    occ = OCC_BYTE3;
            default: occ = OCC_FULL;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/f36_out_reg.sv
// f36_out_reg
//   Single-entry output register for a 36-bit FIFO stream. A word is loaded
//   when load is high and stays presented until the downstream handshake.
//   can_load tells the producer that a load this cycle will not overwrite an
//   unsent word (register empty, or draining in this same cycle).
// Ports
//   clk, reset       clock, synchronous active-high reset (flushes the entry)
//   load, load_data  write strobe and word to store
//   can_load         high when a load this cycle is safe
//   f36_data         presented word (zero while empty after reset)
//   f36_src_rdy_o    word valid
//   f36_dst_rdy_i    downstream accepts the word
module f36_out_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [35:0] load_data,
    output logic        can_load,
    output logic [35:0] f36_data,
    output logic        f36_src_rdy_o,
    input  logic        f36_dst_rdy_i
);

    logic        valid_q, valid_d;
    logic [35:0] data_q,  data_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q & ~f36_dst_rdy_i;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign can_load      = ~valid_q | f36_dst_rdy_i;
    assign f36_data      = data_q;
    assign f36_src_rdy_o = valid_q;

endmodule

// File: rtl/ll_to_fifo36_packer.sv
// ll_to_fifo36_packer
//   Packs a LocalLink stream of LLW-bit beats (8 or 16) into 36-bit FIFO words.
//   Reports per-frame byte length and error status, counts bad frames and
//   discards beats that arrive outside a frame.
// Ports
//   clk, reset, clear     clock, sync active-high reset, sync flush (keeps err_cnt)
//   ll_data .. ll_src_rdy LocalLink input beat and sideband
//   ll_dst_rdy            beat accepted when ll_src_rdy & ll_dst_rdy
//   f36_data, f36_src_rdy_o, f36_dst_rdy_i   36-bit FIFO output handshake
//   frame_done            one-cycle pulse after an eof beat is accepted
//   frame_len, frame_err  result of the completed frame, held to the next frame_done
//   err_cnt               number of frames reported with frame_err (wraps)
module ll_to_fifo36_packer
    import ll_fifo_pkg::*;
#(
    parameter int LLW  = 8,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic [LLW-1:0]  ll_data,
    input  logic            ll_sof,
    input  logic            ll_eof,
    input  logic            ll_half,
    input  logic            ll_error,
    input  logic            ll_src_rdy,
    output logic            ll_dst_rdy,
    output logic [35:0]     f36_data,
    output logic            f36_src_rdy_o,
    input  logic            f36_dst_rdy_i,
    output logic            frame_done,
    output logic [LENW-1:0] frame_len,
    output logic            frame_err,
    output logic [15:0]     err_cnt
);

    if (LLW != 8 && LLW != 16) begin : g_bad_llw
        $error("ll_to_fifo36_packer: LLW must be 8 or 16");
    end

    localparam int LANES = 32 / LLW;
    localparam int BPB   = LLW / 8;     // bytes per full beat

    logic flush;
    assign flush = reset | clear;

    ll_state_e       state_q, state_d;
    logic [31:0]     acc_q, acc_d;       // partial word, unfilled lanes are zero
    logic [1:0]      lane_q, lane_d;     // next lane to fill, 0 = MSB lane
    logic            first_q, first_d;   // next closed word is the frame's first
    logic [LENW-1:0] len_q, len_d;       // bytes so far in the current frame
    logic            err_q, err_d;       // current frame already marked bad
    logic            frame_done_q, frame_done_d;
    logic [LENW-1:0] frame_len_q, frame_len_d;
    logic            frame_err_q, frame_err_d;
    logic [15:0]     err_cnt_q, err_cnt_d;

    logic            pack_beat;
    logic            closing;
    logic            accept;
    logic            half_beat;
    logic [2:0]      beat_bytes;
    logic [31:0]     beat_word;
    logic [31:0]     merged;
    logic [2:0]      word_bytes;
    logic            first_word;
    logic [LENW-1:0] len_base;
    logic [LENW:0]   len_sum;
    logic [LENW-1:0] len_next;
    logic            err_now;
    logic            load;
    logic [35:0]     load_data;
    logic            can_load;

    always_comb begin
        // A beat is packed when it opens a frame from IDLE or arrives mid-frame.
        pack_beat  = (state_q == IDLE && ll_sof) || (state_q == PACK);
        closing    = ll_src_rdy & pack_beat & (ll_eof | (lane_q == 2'(LANES - 1)));
        // Only a word-closing beat needs room in the output register.
        ll_dst_rdy = ~flush & (~closing | can_load);
        accept     = ll_src_rdy & ll_dst_rdy;

        half_beat  = (LLW == 16) && ll_eof && ll_half;
        beat_bytes = half_beat ? 3'd1 : 3'(BPB);

        // Left-align the beat, blank the unused byte of a half beat, then
        // shift it down to its lane.
        beat_word = {ll_data, {(32 - LLW){1'b0}}};
        if (half_beat) begin
            beat_word[23:0] = '0;
        end
        merged     = acc_q | (beat_word >> (LLW * int'(lane_q)));
        word_bytes = 3'(BPB * int'(lane_q) + int'(beat_bytes));
        first_word = (state_q == IDLE) | first_q;

        len_base = (state_q == IDLE) ? '0 : len_q;
        len_sum  = {1'b0, len_base} + (LENW + 1)'(beat_bytes);
        len_next = len_sum[LENW] ? '1 : len_sum[LENW-1:0];

        // A sof inside a frame is packed as data but marks the frame bad.
        err_now = ((state_q == PACK) & err_q) | ll_error | ((state_q == PACK) & ll_sof);

        load      = accept & closing;
        load_data = {4'b0, merged};
        load_data[F36_SOF]               = first_word;
        load_data[F36_EOF]               = ll_eof;
        load_data[F36_OCC_HI:F36_OCC_LO] = occ_from_bytes(word_bytes);
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        lane_d       = lane_q;
        first_d      = first_q;
        len_d        = len_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        frame_err_d  = frame_err_q;

        if (accept) begin
            if (pack_beat) begin
                if (closing) begin
                    acc_d   = '0;
                    lane_d  = '0;
                    first_d = 1'b0;
                end else begin
                    acc_d   = merged;
                    lane_d  = lane_q + 2'd1;
                    first_d = first_word;
                end
                len_d = len_next;
                err_d = err_now;
            end

            case (state_q)
                IDLE: begin
                    if (ll_sof) begin
                        if (ll_eof) begin
                            frame_done_d = 1'b1;
                            frame_len_d  = len_next;
                            frame_err_d  = err_now;
                        end else begin
                            state_d = PACK;
                        end
                    end else if (ll_eof) begin
                        // Single orphan beat: report a bad empty frame.
                        frame_done_d = 1'b1;
                        frame_len_d  = '0;
                        frame_err_d  = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
                PACK: begin
                    if (ll_eof) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        frame_len_d  = len_next;
                        frame_err_d  = err_now;
                    end
                end
                DROP: begin
                    if (ll_eof) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        frame_len_d  = '0;
                        frame_err_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        err_cnt_d = err_cnt_q;
        if (frame_done_d && frame_err_d) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            lane_q       <= '0;
            first_q      <= 1'b1;
            len_q        <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            lane_q       <= lane_d;
            first_q      <= first_d;
            len_q        <= len_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // The bad-frame count survives clear; only reset zeroes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (!clear) begin
            err_cnt_q <= err_cnt_d;
        end
    end

    f36_out_reg u_out_reg (
        .clk           (clk),
        .reset         (flush),
        .load          (load),
        .load_data     (load_data),
        .can_load      (can_load),
        .f36_data      (f36_data),
        .f36_src_rdy_o (f36_src_rdy_o),
        .f36_dst_rdy_i (f36_dst_rdy_i)
    );

    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign frame_err  = frame_err_q;
    assign err_cnt    = err_cnt_q;

endmodule
